// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared types for the front-end redirect controller.
// Optional feature macro: BR_PERF_CNT_EN (performance counters).
package core;

  // Width of the stale-response drain counter (FLUSH_CYCLES range 0..15).
  localparam int FLUSH_CNT_W = 4;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_REDIRECT,
    RD_DRAIN
  } redirect_state_t;

  // Resolved branch information from the EX-stage branch unit.
  typedef struct packed {
    logic        is_taken;
    logic [31:0] branch_target;
  } br_cntrl_bus_t;

endpackage

// File: rtl/branch_redirect_ctrl_if.sv
// Bundle of branch-unit, trap, fetch and perf signals around the redirect controller.
// The slave modport is the controller's view, master is its environment.
interface branch_redirect_ctrl_if #(
  parameter int CNT_W = 32
);
  import core::*;

  logic              br_valid_i;
  br_cntrl_bus_t     br_bus_i;
  logic              ext_flush_i;
  logic              fetch_ready_i;
  logic              redirect_valid_o;
  logic [31:0]       redirect_pc_o;
  logic              flush_ifid_o;
  logic              fetch_discard_o;
  logic              busy_o;
  logic              exc_misalign_o;
  logic [31:0]       exc_tval_o;
  logic [CNT_W-1:0]  perf_br_o;
  logic [CNT_W-1:0]  perf_taken_o;
  logic [CNT_W-1:0]  perf_stall_o;

  modport master (
    output br_valid_i, br_bus_i, ext_flush_i, fetch_ready_i,
    input  redirect_valid_o, redirect_pc_o, flush_ifid_o, fetch_discard_o,
    input  busy_o, exc_misalign_o, exc_tval_o,
    input  perf_br_o, perf_taken_o, perf_stall_o
  );

  modport slave (
    input  br_valid_i, br_bus_i, ext_flush_i, fetch_ready_i,
    output redirect_valid_o, redirect_pc_o, flush_ifid_o, fetch_discard_o,
    output busy_o, exc_misalign_o, exc_tval_o,
    output perf_br_o, perf_taken_o, perf_stall_o
  );

endinterface

// File: rtl/branch_redirect_ctrl_br_perf_cnt.sv
// Three wrapping event counters for the redirect controller.
// Only instantiated when BR_PERF_CNT_EN is defined.
// inc_i[0]: branch seen in idle, inc_i[1]: taken branch, inc_i[2]: busy cycle.
module br_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [2:0]       inc_i,
  output logic [CNT_W-1:0] perf_br_o,
  output logic [CNT_W-1:0] perf_taken_o,
  output logic [CNT_W-1:0] perf_stall_o
);

  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;

    // Wrapping counter; only reset clears it.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cnt_q <= '0;
      end else if (inc_i[gi]) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign perf_br_o    = g_cnt[0].cnt_q;
  assign perf_taken_o = g_cnt[1].cnt_q;
  assign perf_stall_o = g_cnt[2].cnt_q;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Front-end redirect sequencer: flushes IF/ID on a taken branch, holds the
// target until fetch accepts it, then drops FLUSH_CYCLES stale fetch responses.
// Misaligned targets raise an exception instead of redirecting.
// Optional feature macro: BR_PERF_CNT_EN enables the performance counters.
module branch_redirect_ctrl
  import core::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  branch_redirect_ctrl_if.slave  bus
);

  localparam logic [FLUSH_CNT_W-1:0] DRAIN_INIT =
    (FLUSH_CYCLES == 0) ? '0 : FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  redirect_state_t        state_q;
  logic [31:0]            pc_q;
  logic [FLUSH_CNT_W-1:0] cnt_q;

  logic        idle;
  logic        take;
  logic        aligned;
  logic [31:0] target;

  assign idle    = (state_q == RD_IDLE);
  assign target  = bus.br_bus_i.branch_target;
  assign aligned = (target[1:0] == 2'b00);
  // A trap flush in the same cycle suppresses the branch entirely.
  assign take    = bus.br_valid_i & bus.br_bus_i.is_taken & ~bus.ext_flush_i & idle;

  // Redirect FSM: idle -> present target -> drain stale responses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RD_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else if (bus.ext_flush_i) begin
      state_q <= RD_IDLE;
    end else begin
      case (state_q)
        RD_IDLE: begin
          if (take && aligned) begin
            pc_q    <= target;
            state_q <= RD_REDIRECT;
          end
        end
        RD_REDIRECT: begin
          if (bus.fetch_ready_i) begin
            if (FLUSH_CYCLES == 0) begin
              state_q <= RD_IDLE;
            end else begin
              state_q <= RD_DRAIN;
              cnt_q   <= DRAIN_INIT;
            end
          end
        end
        RD_DRAIN: begin
          if (cnt_q == '0) begin
            state_q <= RD_IDLE;
          end else begin
            cnt_q <= cnt_q - FLUSH_CNT_W'(1);
          end
        end
        default: state_q <= RD_IDLE;
      endcase
    end
  end

  assign bus.redirect_valid_o = (state_q == RD_REDIRECT);
  assign bus.redirect_pc_o    = (state_q == RD_REDIRECT) ? pc_q : 32'h0;
  assign bus.flush_ifid_o     = take | ~idle;
  assign bus.fetch_discard_o  = (state_q == RD_DRAIN);
  assign bus.busy_o           = ~idle;
  assign bus.exc_misalign_o   = take & ~aligned;
  assign bus.exc_tval_o       = (take & ~aligned) ? target : 32'h0;

`ifdef BR_PERF_CNT_EN
  br_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_perf (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .inc_i        ({~idle, take, bus.br_valid_i & idle}),
    .perf_br_o    (bus.perf_br_o),
    .perf_taken_o (bus.perf_taken_o),
    .perf_stall_o (bus.perf_stall_o)
  );
`else
  assign bus.perf_br_o    = {CNT_W{1'b0}};
  assign bus.perf_taken_o = {CNT_W{1'b0}};
  assign bus.perf_stall_o = {CNT_W{1'b0}};
`endif

  // The hazard unit must hold EX while the controller is busy.
  assert property (@(posedge clk_i) disable iff (rst_i) !(bus.br_valid_i && !idle));

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl: per-cycle vector checks plus a
// scoreboard of expected redirect handshakes and misalign exceptions.
module tb_branch_redirect_ctrl;
  import core::*;

  logic        clk;
  logic        rst;
  logic        bv;
  logic        bt;
  logic [31:0] tgt;
  logic        ef;
  logic        fr;
  logic        sel;   // 0: drive the FLUSH_CYCLES=2 instance, 1: the FLUSH_CYCLES=0 one

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        is_exc;
    logic [31:0] val;
  } ev_t;
  ev_t exp_q[$];

  branch_redirect_ctrl_if #(.CNT_W(4)) if0 ();
  branch_redirect_ctrl_if #(.CNT_W(4)) if1 ();

  assign if0.br_valid_i    = bv & ~sel;
  assign if0.br_bus_i      = {bt, tgt};
  assign if0.ext_flush_i   = ef;
  assign if0.fetch_ready_i = fr;
  assign if1.br_valid_i    = bv & sel;
  assign if1.br_bus_i      = {bt, tgt};
  assign if1.ext_flush_i   = ef;
  assign if1.fetch_ready_i = fr;

  branch_redirect_ctrl #(.FLUSH_CYCLES(2), .CNT_W(4)) u0 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if0.slave)
  );

  branch_redirect_ctrl #(.FLUSH_CYCLES(0), .CNT_W(4)) u1 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if1.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic push_redir(input logic [31:0] pc);
    ev_t e;
    e.is_exc = 1'b0;
    e.val    = pc;
    exp_q.push_back(e);
  endtask

  task automatic push_exc(input logic [31:0] tval);
    ev_t e;
    e.is_exc = 1'b1;
    e.val    = tval;
    exp_q.push_back(e);
  endtask

  task automatic check_event(input logic is_exc, input logic [31:0] val, input string nm);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: unexpected event value=%h, nothing expected", nm, val);
    end else begin
      e = exp_q.pop_front();
      if (e.is_exc !== is_exc || e.val !== val) begin
        bad++;
        $display("FAIL %s: got exc=%b val=%h, expected exc=%b val=%h", nm, is_exc, val, e.is_exc, e.val);
      end else begin
        $display("event %s val=%h ok", nm, val);
      end
    end
  endtask

  // Monitor: pops the scoreboard whenever instance 0 completes a redirect or raises an exception.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        if (if0.redirect_valid_o && fr) check_event(1'b0, if0.redirect_pc_o, "redirect");
        if (if0.exc_misalign_o)         check_event(1'b1, if0.exc_tval_o, "misalign");
      end
    end
  end

  // One cycle: drive inputs at the falling edge, check outputs, advance to the next falling edge.
  // e = {flush_ifid, redirect_valid, fetch_discard, busy, exc_misalign}
  task automatic cyc(input string nm, input logic i_bv, input logic i_bt, input logic [31:0] i_tgt,
                     input logic i_ef, input logic i_fr, input logic [4:0] e, input logic [31:0] e_pc);
    logic [4:0]  act;
    logic [31:0] act_pc;
    bv = i_bv; bt = i_bt; tgt = i_tgt; ef = i_ef; fr = i_fr;
    #1;
    if (sel) begin
      act    = {if1.flush_ifid_o, if1.redirect_valid_o, if1.fetch_discard_o, if1.busy_o, if1.exc_misalign_o};
      act_pc = if1.redirect_pc_o;
    end else begin
      act    = {if0.flush_ifid_o, if0.redirect_valid_o, if0.fetch_discard_o, if0.busy_o, if0.exc_misalign_o};
      act_pc = if0.redirect_pc_o;
    end
    total += 2;
    if (act !== e) begin
      bad++;
      $display("FAIL %s flags: got=%b exp=%b", nm, act, e);
    end
    if (act_pc !== e_pc) begin
      bad++;
      $display("FAIL %s pc: got=%h exp=%h", nm, act_pc, e_pc);
    end
    $display("cycle %s flags=%b pc=%h", nm, act, act_pc);
    @(negedge clk);
  endtask

  task automatic check_perf(input string nm, input logic [3:0] a, input logic [3:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", nm, a, e);
    end else begin
      $display("perf %s=%0d ok", nm, a);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bv = 1'b0; bt = 1'b0; tgt = 32'h0; ef = 1'b0; fr = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    sel = 1'b0;
    do_reset();
    // Reset state of both instances (rst still high)
    cyc("reset_u0", 0, 0, 32'h0, 0, 0, 5'b00000, 32'h0);
    check_perf("reset_br", if0.perf_br_o, 4'd0);
    check_perf("reset_taken", if0.perf_taken_o, 4'd0);
    check_perf("reset_stall", if0.perf_stall_o, 4'd0);
    sel = 1'b1;
    cyc("reset_u1", 0, 0, 32'h0, 0, 0, 5'b00000, 32'h0);
    sel = 1'b0;
    rst = 1'b0;

    // 1: BEQ taken to 0x100, fetch ready immediately
    push_redir(32'h100);
    cyc("t1_take",   1, 1, 32'h100, 0, 1, 5'b10000, 32'h0);
    cyc("t1_redir",  0, 0, 32'h0,   0, 1, 5'b11010, 32'h100);
    cyc("t1_drain0", 0, 0, 32'h0,   0, 0, 5'b10110, 32'h0);
    cyc("t1_drain1", 0, 0, 32'h0,   0, 0, 5'b10110, 32'h0);
    cyc("t1_idle",   0, 0, 32'h0,   0, 0, 5'b00000, 32'h0);

    // 2: fetch stalls 3 cycles; target held stable
    push_redir(32'h2000);
    cyc("t2_take",   1, 1, 32'h2000, 0, 0, 5'b10000, 32'h0);
    for (int i = 0; i < 3; i++)
      cyc("t2_hold", 0, 0, 32'h0,    0, 0, 5'b11010, 32'h2000);
    cyc("t2_accept", 0, 0, 32'h0,    0, 1, 5'b11010, 32'h2000);
    cyc("t2_drain0", 0, 0, 32'h0,    0, 0, 5'b10110, 32'h0);
    cyc("t2_drain1", 0, 0, 32'h0,    0, 0, 5'b10110, 32'h0);
    cyc("t2_idle",   0, 0, 32'h0,    0, 0, 5'b00000, 32'h0);

    // 3: JALR to misaligned 0x202 -> exception, no redirect
    push_exc(32'h202);
    cyc("t3_jalr",   1, 1, 32'h202, 0, 1, 5'b10001, 32'h0);
    cyc("t3_idle",   0, 0, 32'h0,   0, 1, 5'b00000, 32'h0);

    // 4: trap flush during redirect, then alongside taken branches
    cyc("t4_take",   1, 1, 32'h300, 0, 0, 5'b10000, 32'h0);
    cyc("t4_flush",  0, 0, 32'h0,   1, 0, 5'b11010, 32'h300);
    cyc("t4_bne_ef", 1, 1, 32'h400, 1, 0, 5'b00000, 32'h0);
    cyc("t4_mis_ef", 1, 1, 32'h402, 1, 0, 5'b00000, 32'h0);
    cyc("t4_quiet",  0, 0, 32'h0,   0, 1, 5'b00000, 32'h0);
    push_redir(32'h500);
    cyc("t4_take2",  1, 1, 32'h500, 0, 1, 5'b10000, 32'h0);
    cyc("t4_redir2", 0, 0, 32'h0,   0, 1, 5'b11010, 32'h500);
    cyc("t4_drn0",   0, 0, 32'h0,   0, 0, 5'b10110, 32'h0);
    cyc("t4_drn1",   0, 0, 32'h0,   0, 0, 5'b10110, 32'h0);
    cyc("t4_idle",   0, 0, 32'h0,   0, 0, 5'b00000, 32'h0);

    // 5: FLUSH_CYCLES=0 instance: no drain; not-taken BLT does nothing
    sel = 1'b1;
    cyc("t5_take",   1, 1, 32'h600, 0, 1, 5'b10000, 32'h0);
    cyc("t5_redir",  0, 0, 32'h0,   0, 1, 5'b11010, 32'h600);
    cyc("t5_idle",   0, 0, 32'h0,   0, 0, 5'b00000, 32'h0);
    cyc("t5_blt",    1, 0, 32'h700, 0, 0, 5'b00000, 32'h0);
    cyc("t5_after",  0, 0, 32'h0,   0, 0, 5'b00000, 32'h0);
    sel = 1'b0;
    cyc("t5_blt_u0", 1, 0, 32'h700, 0, 1, 5'b00000, 32'h0);

    // 6: fresh counters, 17 misaligned taken branches -> 4-bit counters wrap to 1
    do_reset();
    rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      push_exc(32'h1001 + 32'(i) * 32'd4);
      cyc("t6_take", 1, 1, 32'h1001 + 32'(i) * 32'd4, 0, 0, 5'b10001, 32'h0);
    end
    bv = 1'b0; bt = 1'b0;
`ifdef BR_PERF_CNT_EN
    check_perf("t6_br",    if0.perf_br_o,    4'd1);
    check_perf("t6_taken", if0.perf_taken_o, 4'd1);
    check_perf("t6_stall", if0.perf_stall_o, 4'd0);
`else
    check_perf("t6_br",    if0.perf_br_o,    4'd0);
    check_perf("t6_taken", if0.perf_taken_o, 4'd0);
    check_perf("t6_stall", if0.perf_stall_o, 4'd0);
`endif

    #3;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d events never seen, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
